// File: rtl/atm_amount_entry.sv
// ATM keypad front-end: debounces raw key codes into single press events and runs
// the balance / two-digit withdrawal state machine that drives the display bus.
module atm_amount_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int INIT_BALANCE    = 50,
  parameter int HOLD_CYCLES     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [9:0] num,
  output logic [1:0] mode,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_SHOW_BAL = 2'b00,
    ST_ENTRY    = 2'b01,
    ST_RESULT   = 2'b10
  } state_t;

  localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [7:0]      DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]      BAL_INIT  = 7'(INIT_BALANCE);
  localparam logic [3:0]      KEY_CLEAR = 4'd10;
  localparam logic [3:0]      KEY_BACK  = 4'd11;
  localparam logic [3:0]      KEY_ENTER = 4'd12;

  logic        r_db_armed;
  logic [7:0]  r_db_cnt;
  logic [3:0]  r_db_code;
  logic        r_evt;
  logic [3:0]  r_evt_code;

  state_t      r_state;
  logic [6:0]  r_balance;
  logic [6:0]  r_entry;
  logic [1:0]  r_digits;
  logic [HW-1:0] r_hold;
  logic [9:0]  r_num;
  logic        r_done;
  logic        r_err;

  state_t      w_state_nxt;
  logic [6:0]  w_balance_nxt;
  logic [6:0]  w_entry_nxt;
  logic [1:0]  w_digits_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic        w_accept;
  logic        w_reject;
  logic [9:0]  w_num_nxt;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_is_digit;

  assign w_is_digit = (r_evt_code <= 4'd9);

  // Debouncer: armed counts a stable held code, disarmed counts a stable release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_armed <= 1'b1;
      r_db_cnt   <= 8'd0;
      r_db_code  <= 4'd0;
      r_evt      <= 1'b0;
      r_evt_code <= 4'd0;
    end else begin
      r_evt <= 1'b0;
      if (r_db_armed) begin
        if (key_valid) begin
          if ((r_db_cnt != 8'd0) && (key_code == r_db_code)) begin
            if (r_db_cnt == DB_LAST) begin
              r_evt      <= 1'b1;
              r_evt_code <= key_code;
              r_db_armed <= 1'b0;
              r_db_cnt   <= 8'd0;
            end else begin
              r_db_cnt <= r_db_cnt + 8'd1;
            end
          end else begin
            // First held sample or a code change starts a fresh qualification.
            r_db_cnt  <= 8'd1;
            r_db_code <= key_code;
          end
        end else begin
          r_db_cnt <= 8'd0;
        end
      end else begin
        if (key_valid) begin
          r_db_cnt <= 8'd0;
        end else if (r_db_cnt == DB_LAST) begin
          r_db_armed <= 1'b1;
          r_db_cnt   <= 8'd0;
        end else begin
          r_db_cnt <= r_db_cnt + 8'd1;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SHOW_BAL;
      r_balance <= BAL_INIT;
      r_entry   <= 7'd0;
      r_digits  <= 2'd0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_balance <= w_balance_nxt;
      r_entry   <= w_entry_nxt;
      r_digits  <= w_digits_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  // Next-state and datapath update from the registered key event.
  always_comb begin
    w_state_nxt   = r_state;
    w_balance_nxt = r_balance;
    w_entry_nxt   = r_entry;
    w_digits_nxt  = r_digits;
    w_hold_nxt    = r_hold;
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    case (r_state)
      ST_SHOW_BAL: begin
        if (r_evt && w_is_digit) begin
          w_state_nxt  = ST_ENTRY;
          w_entry_nxt  = {3'b000, r_evt_code};
          w_digits_nxt = 2'd1;
        end else begin
          w_state_nxt = ST_SHOW_BAL;
        end
      end
      ST_ENTRY: begin
        if (!r_evt) begin
          w_state_nxt = ST_ENTRY;
        end else if (w_is_digit) begin
          if (r_digits == 2'd1) begin
            w_entry_nxt  = (r_entry * 7'd10) + {3'b000, r_evt_code};
            w_digits_nxt = 2'd2;
          end else begin
            w_digits_nxt = r_digits;
          end
        end else if (r_evt_code == KEY_BACK) begin
          w_entry_nxt  = r_entry / 7'd10;
          w_digits_nxt = r_digits - 2'd1;
          if (r_digits == 2'd1) begin
            w_state_nxt = ST_SHOW_BAL;
          end else begin
            w_state_nxt = ST_ENTRY;
          end
        end else if (r_evt_code == KEY_CLEAR) begin
          w_entry_nxt  = 7'd0;
          w_digits_nxt = 2'd0;
          w_state_nxt  = ST_SHOW_BAL;
        end else if (r_evt_code == KEY_ENTER) begin
          if ((r_entry != 7'd0) && (r_entry <= r_balance)) begin
            w_balance_nxt = r_balance - r_entry;
            w_accept      = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
          w_state_nxt = ST_RESULT;
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt = ST_ENTRY;
        end
      end
      ST_RESULT: begin
        // Key events are dropped here; only the hold timer matters.
        if (r_hold == HOLD_LAST) begin
          w_state_nxt  = ST_SHOW_BAL;
          w_entry_nxt  = 7'd0;
          w_digits_nxt = 2'd0;
          w_hold_nxt   = '0;
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_SHOW_BAL;
      end
    endcase
  end

  // Output decode from the next state so outputs land on the same edge as the state.
  always_comb begin
    w_num_nxt  = {3'b000, w_entry_nxt};
    w_done_nxt = w_accept;
    w_err_nxt  = 1'b0;
    if (w_state_nxt == ST_SHOW_BAL) begin
      w_num_nxt = {3'b000, w_balance_nxt};
    end else begin
      w_num_nxt = {3'b000, w_entry_nxt};
    end
    if (w_reject) begin
      w_err_nxt = 1'b1;
    end else if ((r_state == ST_RESULT) && (w_state_nxt == ST_RESULT)) begin
      w_err_nxt = r_err;
    end else begin
      w_err_nxt = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num  <= {3'b000, BAL_INIT};
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_num  <= w_num_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign num  = r_num;
  assign mode = r_state;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_atm_amount_entry.sv
// Randomised bench for atm_amount_entry: a sliding-window debounce model plus a
// plain-arithmetic account model predict every output on every cycle.
module tb_atm_amount_entry;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int INIT = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [9:0] num;
  logic [1:0] mode;
  logic       done;
  logic       err;

  atm_amount_entry #(
    .DEBOUNCE_CYCLES(DB),
    .INIT_BALANCE   (INIT),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .num      (num),
    .mode     (mode),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  // Model: last DB samples (-1 = released, -2 = nothing since reset).
  int m_hist[DB];
  bit m_armed;
  bit m_evt;
  int m_evt_code;
  int m_state, m_bal, m_ent, m_dig, m_rem;
  bit m_done, m_err;

  function automatic void model_reset();
    for (int i = 0; i < DB; i++) m_hist[i] = -2;
    m_armed = 1'b1; m_evt = 1'b0; m_evt_code = 0;
    m_state = 0; m_bal = INIT; m_ent = 0; m_dig = 0; m_rem = 0;
    m_done = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_step(bit v, int c);
    bit same;
    m_done = 1'b0;
    case (m_state)
      0: begin
        if (m_evt && m_evt_code <= 9) begin
          m_state = 1; m_ent = m_evt_code; m_dig = 1;
        end
      end
      1: begin
        if (m_evt) begin
          if (m_evt_code <= 9) begin
            if (m_dig == 1) begin m_ent = m_ent * 10 + m_evt_code; m_dig = 2; end
          end else if (m_evt_code == 11) begin
            m_ent = m_ent / 10; m_dig = m_dig - 1;
            if (m_dig == 0) m_state = 0;
          end else if (m_evt_code == 10) begin
            m_ent = 0; m_dig = 0; m_state = 0;
          end else if (m_evt_code == 12) begin
            if (m_ent > 0 && m_ent <= m_bal) begin
              m_bal = m_bal - m_ent; m_done = 1'b1; m_err = 1'b0;
            end else begin
              m_err = 1'b1;
            end
            m_state = 2; m_rem = HOLD;
          end
        end
      end
      2: begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_state = 0; m_err = 1'b0; m_ent = 0; m_dig = 0;
        end
      end
      default: m_state = 0;
    endcase
    for (int i = 0; i < DB - 1; i++) m_hist[i] = m_hist[i+1];
    m_hist[DB-1] = v ? c : -1;
    same = 1'b1;
    for (int i = 1; i < DB; i++) if (m_hist[i] != m_hist[0]) same = 1'b0;
    m_evt = 1'b0;
    if (m_armed && same && m_hist[0] >= 0) begin
      m_evt = 1'b1; m_evt_code = m_hist[0]; m_armed = 1'b0;
    end else if (!m_armed && same && m_hist[0] == -1) begin
      m_armed = 1'b1;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("num",  int'(num),  (m_state == 0) ? m_bal : m_ent);
    check("mode", int'(mode), m_state);
    check("done", int'(done), int'(m_done));
    check("err",  int'(err),  int'(m_err));
    if (done) done_seen++;
  endtask

  task automatic tick(input bit v, input int c);
    key_valid = v;
    key_code  = 4'(c);
    @(posedge clk);
    model_step(v, c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input int c, input int hold, input int rel);
    repeat (hold) tick(1'b1, c);
    repeat (rel) tick(1'b0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0);
  endtask

  // Asynchronous reset asserted between edges and checked before any clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = 4'd0;
    #1;
    model_reset();
    compare_all();
    check("rst_num", int'(num), INIT);
    check("rst_mode", int'(mode), 0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int c, hold, rel;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Short glitch must not register.
    repeat (3) tick(1'b1, 3);
    idle(6);
    check("glitch_num", int'(num), 50);
    check("glitch_mode", int'(mode), 0);

    // Successful withdrawal of 25.
    press(2, DB + 1, DB);
    check("w_num_2", int'(num), 2);
    press(5, DB + 1, DB);
    check("w_num_25", int'(num), 25);
    press(12, DB + 1, DB);
    check("w_mode_res", int'(mode), 2);
    check("w_res_num", int'(num), 25);
    idle(6);
    check("w_mode_back", int'(mode), 0);
    check("w_bal", int'(num), 25);
    check("w_done_cnt", done_seen, 1);

    // Rejected withdrawals: too large, then zero.
    press(3, DB + 1, DB);
    press(0, DB + 1, DB);
    press(12, DB + 1, DB);
    check("r_err", int'(err), 1);
    idle(6);
    check("r_bal", int'(num), 25);
    check("r_err_clr", int'(err), 0);
    check("r_done_cnt", done_seen, 1);
    press(0, DB + 1, DB);
    press(12, DB + 1, DB);
    check("r_err_zero", int'(err), 1);
    idle(6);

    // Entry editing.
    press(9, DB + 1, DB);
    press(8, DB + 1, DB);
    press(7, DB + 1, DB);
    check("e_98", int'(num), 98);
    press(11, DB + 1, DB);
    check("e_back", int'(num), 9);
    press(11, DB + 1, DB);
    check("e_back2_mode", int'(mode), 0);
    check("e_back2_num", int'(num), 25);
    press(4, DB + 1, DB);
    press(10, DB + 1, DB);
    check("e_clear_mode", int'(mode), 0);

    // Long hold, code change mid-qualification, release glitch.
    press(7, 20, DB);
    check("h_single", int'(num), 7);
    repeat (2) tick(1'b1, 7);
    repeat (3) tick(1'b1, 8);
    check("h_nochg", int'(num), 7);
    repeat (2) tick(1'b1, 8);
    check("h_78", int'(num), 78);
    idle(DB);
    press(10, DB + 1, DB);
    repeat (5) tick(1'b1, 1);
    idle(2);
    repeat (5) tick(1'b1, 1);
    idle(DB);
    check("h_bounce", int'(num), 1);
    press(10, DB + 1, DB);

    // Reset mid-ENTRY and mid-RESULT.
    press(2, DB + 1, DB);
    do_reset();
    press(1, DB + 1, DB);
    press(12, DB + 1, DB);
    check("x_in_res", int'(mode), 2);
    do_reset();
    check("x_err", int'(err), 0);

    // A press qualifying on the last RESULT cycle is consumed.
    press(1, DB + 1, DB);
    press(12, DB, DB);
    press(5, DB, DB);
    check("l_mode", int'(mode), 0);
    check("l_num", int'(num), 49);
    idle(2);
    check("l_num2", int'(num), 49);

    // Randomised presses, bounces and code changes.
    for (int k = 0; k < 300; k++) begin
      if (k % 75 == 74) do_reset();
      c    = ($urandom_range(0, 9) < 6) ? $urandom_range(0, 9) : $urandom_range(10, 15);
      hold = $urandom_range(1, 8);
      rel  = $urandom_range(1, 7);
      for (int j = 0; j < hold; j++) begin
        if ($urandom_range(0, 9) == 0) c = $urandom_range(0, 15);
        tick(1'b1, c);
      end
      idle(rel);
    end
    idle(HOLD + 2 * DB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_amount_entry.md
# atm_amount_entry

Keypad front-end of the ATM display path. It debounces raw keypad codes and runs the balance/withdrawal state machine. It accumulates a two-digit withdrawal amount and drives the registered 10-bit `num` bus consumed by the ones/tens seven-segment decoder stage. `num` is always in 0..99, so the tens digit (`num/10`) is always a valid 0..9 decoder input.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples needed to accept a press or a release; legal range 2..255.
- `INIT_BALANCE`, 50: balance loaded at reset; legal range 0..99.
- `HOLD_CYCLES`, 1000: cycles the RESULT state is displayed before returning to SHOW_BAL; legal range ≥1.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: raw keypad "key held" level.
- `key_code` in 4: raw key code. 0–9 are digits, 10 = CLEAR, 11 = BACK, 12 = ENTER, 13–15 are ignored.
- `num` out 10: value shown on the display; always 0..99, zero-extended.
- `mode` out 2: current state. 00 = SHOW_BAL, 01 = ENTRY, 10 = RESULT; 11 never occurs.
- `done` out 1: one-cycle pulse on a successful withdrawal.
- `err` out 1: ENTER was rejected; held high until the state leaves RESULT.

## Operation
- **Debounce and press event**
  - A press event fires when `key_valid`=1 and `key_code` is unchanged for `DEBOUNCE_CYCLES` consecutive samples.
  - Exactly one event fires per press. A code change while held restarts the count.
  - Re-arm requires `key_valid`=0 for `DEBOUNCE_CYCLES` consecutive samples. A bounce high during re-arm restarts the release count and produces no event.
  - Events carry the code sampled at acceptance.
- **State and arithmetic**
  - Internal state: `balance` (7 bits), `entry` (7 bits), `digits` (0..2), hold counter.
- **SHOW_BAL**
  - `num` = `balance`.
  - Digit d: go to ENTRY with `entry`=d, `digits`=1.
  - CLEAR, BACK, ENTER and codes 13–15 are ignored.
- **ENTRY**
  - `num` = `entry`.
  - Digit d with `digits`=1: `entry`=`entry`*10+d, `digits`=2.
  - Digit with `digits`=2: ignored.
  - BACK: `entry`=`entry`/10 and `digits`−1. If `digits` reaches 0, go to SHOW_BAL.
  - CLEAR: `entry`=0, `digits`=0, go to SHOW_BAL.
  - ENTER:
    - If 0 < `entry` ≤ `balance`: `balance` −= `entry`, pulse `done`, `err`=0.
    - Otherwise: `err`=1 and `balance` is unchanged.
    - Either way, go to RESULT.
- **RESULT**
  - `num` = `entry`.
  - All key events are ignored.
  - After `HOLD_CYCLES` cycles, go to SHOW_BAL. On that transition `err`=0, `entry`=0, `digits`=0.
- **Events inside RESULT**
  - A press accepted during RESULT is consumed (the debouncer still requires release). It is never replayed later.
- **Reset values** (on `rst_n`=0, immediately and asynchronously)
  - `mode`=00, `num`=`INIT_BALANCE`, `balance`=`INIT_BALANCE`.
  - `entry`=0, `digits`=0, `done`=0, `err`=0.
  - Debouncer counters cleared and in the armed state.
  - Reset mid-press: the press must be fully re-qualified after release.

## Timing
- **Sample timing:** `key_valid`/`key_code` are sampled on each rising edge. The first high sample is edge 1.
- **Event edge:** the press event registers on edge `DEBOUNCE_CYCLES`.
- **Output latency:**
  - `mode`, `num`, `done` and `err` update on edge `DEBOUNCE_CYCLES`+1.
  - The downstream decoder adds its own one-cycle register.
- **`done`:** high for exactly one cycle, the same cycle `mode` first reads 10.
- **RESULT duration:** `mode`=10 for exactly `HOLD_CYCLES` cycles. `num` shows the updated balance on the same edge that `mode` returns to 00.
- **Throughput:** at most one key event per press/release cycle. Minimum spacing is 2×`DEBOUNCE_CYCLES` cycles.
- **Combinational paths:** no combinational path from any input to any output.

## Test plan
Unless stated otherwise: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=8, `INIT_BALANCE`=50.

1. **Reset and glitch rejection:** release reset; hold `key_valid`=1 with code 3 for 3 cycles, then low. Required: `num`=50 and `mode`=00 throughout.
2. **Successful withdrawal:** clean presses 2, 5, ENTER. Required:
   - `num` shows 2 then 25.
   - `done` pulses once; `mode`=10 for 8 cycles with `num`=25.
   - Then `mode`=00 with `num`=25 (balance 50−25).
3. **Rejected withdrawal:** from balance 25, press 3, 0, ENTER. Required: `err`=1 for the RESULT period, no `done`, then `num`=25 again. Also: press 0, ENTER gives `err`=1.
4. **Entry editing:**
   - Press 9, 8, 7: required `num`=98 (third digit ignored).
   - BACK: required `num`=9. BACK again: required `mode`=00, `num`=balance.
   - Press 4 then CLEAR: required `mode`=00.
5. **Held key, code change and bounce:**
   - Hold code 7 for 20 cycles: required exactly one event.
   - Change code 7→8 mid-qualification: no event until 8 has been stable for 4 cycles.
   - A 2-cycle release glitch followed by re-press: no second event.
6. **Reset mid-operation and RESULT lockout:**
   - Assert `rst_n`=0 asynchronously mid-ENTRY and mid-RESULT: all outputs return to reset values immediately.
   - A key press during RESULT: no effect after returning to SHOW_BAL.
